// File: rtl/panel_cmd_seq.sv
// panel_cmd_seq: front-panel command sequencer (define PANEL_EXAMINE_EN to add the examine command)
module panel_cmd_seq #(
  parameter int ACK_TIMEOUT = 15,
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             loadpc,
  input  logic             loadac,
  input  logic             deposit,
  input  logic             step,
  input  logic [WIDTH-1:0] swreg,
  input  logic [1:0]       dispsel,
  input  logic [WIDTH-1:0] cpu_pc,
  input  logic [WIDTH-1:0] cpu_ac,
  input  logic [WIDTH-1:0] cpu_ir,
  input  logic             cpu_link,
  input  logic             cpu_done,
  input  logic             cpu_halted,
  output logic             pc_load,
  output logic             ac_load,
  output logic             pc_inc,
  output logic [WIDTH-1:0] ld_data,
  output logic             cpu_go,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
`ifdef PANEL_EXAMINE_EN
  input  logic             examine,
  input  logic [WIDTH-1:0] mem_rdata,
`endif
  output logic [WIDTH-1:0] dispout,
  output logic             linkout,
  output logic             halt,
  output logic             busy,
  output logic             err
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);
  typedef enum logic [2:0] {
    IDLE, DEP_WR, DEP_INC, STEP_WAIT, RUN, RUN_STOP
`ifdef PANEL_EXAMINE_EN
    , EXAM_RD
`endif
  } state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] mb, mb_n, rd_sel;
  logic err_n, halt_n, pc_load_n, ac_load_n, step_go, step_go_n, cap_ld, cap_mem, mem_st;
`ifdef PANEL_EXAMINE_EN
  assign mem_st = state == DEP_WR || state == EXAM_RD;
  assign rd_sel = state == EXAM_RD ? mem_rdata : ld_data;
`else
  assign mem_st = state == DEP_WR;
  assign rd_sel = ld_data;
`endif
  assign mem_req = mem_st;
  assign mem_we = state == DEP_WR;
  assign mem_wdata = ld_data;
  assign pc_inc = state == DEP_INC;
  assign cpu_go = state == RUN || step_go;
  assign busy = state != IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      mb <= '0;
      err <= 1'b0;
      halt <= 1'b0;
      pc_load <= 1'b0;
      ac_load <= 1'b0;
      step_go <= 1'b0;
      ld_data <= '0;
      mem_addr <= '0;
      dispout <= '0;
      linkout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mb <= mb_n;
      err <= err_n;
      halt <= halt_n;
      pc_load <= pc_load_n;
      ac_load <= ac_load_n;
      step_go <= step_go_n;
      if (cap_ld) ld_data <= swreg;
      if (cap_mem) mem_addr <= cpu_pc;
      dispout <= dispsel == 2'd0 ? cpu_pc : dispsel == 2'd1 ? cpu_ac : dispsel == 2'd2 ? mb : cpu_ir;
      linkout <= cpu_link;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mb_n = mb;
    err_n = err;
    halt_n = 1'b0;
    pc_load_n = 1'b0;
    ac_load_n = 1'b0;
    step_go_n = 1'b0;
    cap_ld = 1'b0;
    cap_mem = 1'b0;
    if (mem_st) begin
      if (mem_ack) begin
        mb_n = rd_sel;
        state_n = DEP_INC;
      end else if (cnt == LAST) begin
        err_n = 1'b1;
        halt_n = 1'b1;
        state_n = IDLE;
      end else cnt_n = cnt + CW'(1);
    end else begin
      case (state)
        IDLE:
          if (run) state_n = RUN;
          else if (loadpc) begin
            pc_load_n = 1'b1;
            cap_ld = 1'b1;
            err_n = 1'b0;
          end else if (loadac) begin
            ac_load_n = 1'b1;
            cap_ld = 1'b1;
          end else if (deposit) begin
            state_n = DEP_WR;
            cap_ld = 1'b1;
            cap_mem = 1'b1;
            cnt_n = '0;
          end else if (step) begin
            state_n = STEP_WAIT;
            step_go_n = 1'b1;
          end
`ifdef PANEL_EXAMINE_EN
          else if (examine) begin
            state_n = EXAM_RD;
            cap_mem = 1'b1;
            cnt_n = '0;
          end
`endif
        DEP_INC: state_n = IDLE;
        STEP_WAIT, RUN_STOP:
          if (cpu_halted) begin
            halt_n = 1'b1;
            state_n = IDLE;
          end else if (cpu_done) state_n = IDLE;
        RUN:
          if (cpu_halted) begin
            halt_n = 1'b1;
            state_n = IDLE;
          end else if (!run) state_n = RUN_STOP;
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_panel_cmd_seq.sv
// tb_panel_cmd_seq: directed panel commands, scoreboard of expected output events
module tb_panel_cmd_seq;
  logic clock = 1'b0, reset = 1'b1, run = 1'b0, loadpc = 1'b0, loadac = 1'b0, deposit = 1'b0, step = 1'b0;
  logic [11:0] swreg = '0, cpu_pc = '0, cpu_ac = '0, cpu_ir = '0;
  logic [1:0] dispsel = '0;
  logic cpu_link = 1'b0, cpu_done = 1'b0, cpu_halted = 1'b0, mem_ack = 1'b0;
  logic pc_load, ac_load, pc_inc, cpu_go, mem_req, mem_we, linkout, halt, busy, err;
  logic [11:0] ld_data, mem_addr, mem_wdata, dispout;

  panel_cmd_seq dut (
    .clock(clock), .reset(reset), .run(run), .loadpc(loadpc), .loadac(loadac),
    .deposit(deposit), .step(step), .swreg(swreg), .dispsel(dispsel),
    .cpu_pc(cpu_pc), .cpu_ac(cpu_ac), .cpu_ir(cpu_ir), .cpu_link(cpu_link),
    .cpu_done(cpu_done), .cpu_halted(cpu_halted), .pc_load(pc_load), .ac_load(ac_load),
    .pc_inc(pc_inc), .ld_data(ld_data), .cpu_go(cpu_go), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
`ifdef PANEL_EXAMINE_EN
    .examine(1'b0), .mem_rdata(12'd0),
`endif
    .dispout(dispout), .linkout(linkout), .halt(halt), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  localparam logic [3:0] K_PCLD = 4'd1, K_ACLD = 4'd2, K_MREQ = 4'd3, K_INC = 4'd4,
                         K_GOUP = 4'd5, K_GODN = 4'd6, K_HALT = 4'd7, K_IDLE = 4'd8;
  typedef struct packed {logic [3:0] k; logic [31:0] d;} ev_t;
  ev_t exp_q[$];
  int nvec = 0, nmis = 0;
  logic p_req = 1'b0, p_go = 1'b0, p_busy = 1'b0;

  task automatic expect_ev(input logic [3:0] k, input logic [31:0] d);
    ev_t e;
    e.k = k;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic got(input logic [3:0] k, input logic [31:0] d);
    ev_t e;
    nvec++;
    if (exp_q.size() == 0) begin
      nmis++;
      $display("FAIL unexpected_event: got kind=%0d data=%h, required none", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.k !== k || e.d !== d) begin
        nmis++;
        $display("FAIL event: got kind=%0d data=%h, required kind=%0d data=%h", k, d, e.k, e.d);
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (pc_load) got(K_PCLD, 32'(ld_data));
      if (ac_load) got(K_ACLD, 32'(ld_data));
      if (mem_req && !p_req) got(K_MREQ, {7'd0, mem_we, mem_addr, mem_wdata});
      if (pc_inc) got(K_INC, 32'(mem_addr));
      if (cpu_go && !p_go) got(K_GOUP, 32'd0);
      if (!cpu_go && p_go) got(K_GODN, 32'd0);
      if (halt) got(K_HALT, 32'(err));
      if (!busy && p_busy) got(K_IDLE, 32'd0);
    end
    p_req <= mem_req;
    p_go <= cpu_go;
    p_busy <= busy;
  end

  initial begin
    int n;
    tick(3);
    check("reset_outs", 64'({pc_load, ac_load, pc_inc, cpu_go, mem_req, mem_we, halt, busy, err, linkout,
                             ld_data, mem_addr, mem_wdata, dispout}), 64'd0);
    reset = 1'b0;
    tick(2);
    // reset while a deposit waits for its ack
    cpu_pc = 12'o0100;
    swreg = 12'o1111;
    expect_ev(K_MREQ, {7'd0, 1'b1, 12'o0100, 12'o1111});
    deposit = 1'b1;
    tick(1);
    deposit = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    check("reset_mid_dep", 64'({mem_req, pc_inc, err, busy, dispout}), 64'd0);
    reset = 1'b0;
    tick(3);
    // loadpc
    swreg = 12'o1234;
    expect_ev(K_PCLD, 32'(12'o1234));
    loadpc = 1'b1;
    tick(1);
    loadpc = 1'b0;
    tick(1);
    check("pc_load_once", 64'(pc_load), 64'd0);
    // deposit with ack in the third wait cycle
    cpu_pc = 12'o0200;
    swreg = 12'o7402;
    expect_ev(K_MREQ, {7'd0, 1'b1, 12'o0200, 12'o7402});
    expect_ev(K_INC, 32'(12'o0200));
    expect_ev(K_IDLE, 32'd0);
    deposit = 1'b1;
    tick(1);
    deposit = 1'b0;
    tick(2);
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    dispsel = 2'd2;
    tick(3);
    check("disp_mb", 64'(dispout), 64'(12'o7402));
    // deposit that never gets an ack
    cpu_pc = 12'o0300;
    swreg = 12'o5555;
    expect_ev(K_MREQ, {7'd0, 1'b1, 12'o0300, 12'o5555});
    expect_ev(K_HALT, 32'd1);
    expect_ev(K_IDLE, 32'd0);
    deposit = 1'b1;
    tick(1);
    deposit = 1'b0;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick(1);
    end
    check("timeout_len", 64'(n), 64'd15);
    check("err_set", 64'(err), 64'd1);
    tick(2);
    check("mb_kept", 64'(dispout), 64'(12'o7402));
    swreg = 12'o0007;
    expect_ev(K_PCLD, 32'(12'o0007));
    loadpc = 1'b1;
    tick(1);
    loadpc = 1'b0;
    check("err_cleared", 64'(err), 64'd0);
    // loadac beats step in the same cycle
    swreg = 12'o4321;
    expect_ev(K_ACLD, 32'(12'o4321));
    loadac = 1'b1;
    step = 1'b1;
    tick(1);
    loadac = 1'b0;
    step = 1'b0;
    tick(2);
    check("step_dropped", 64'(busy), 64'd0);
    expect_ev(K_GOUP, 32'd0);
    expect_ev(K_GODN, 32'd0);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(3);
    check("step_busy", 64'(busy), 64'd1);
    loadpc = 1'b1;
    tick(1);
    loadpc = 1'b0;
    tick(2);
    expect_ev(K_IDLE, 32'd0);
    cpu_done = 1'b1;
    tick(1);
    cpu_done = 1'b0;
    tick(2);
    // run, stopped by HLT
    expect_ev(K_GOUP, 32'd0);
    run = 1'b1;
    tick(4);
    check("run_go", 64'({cpu_go, busy}), 64'd3);
    expect_ev(K_GODN, 32'd0);
    expect_ev(K_HALT, 32'd0);
    expect_ev(K_IDLE, 32'd0);
    cpu_halted = 1'b1;
    tick(1);
    cpu_halted = 1'b0;
    run = 1'b0;
    tick(2);
    check("halt_idle", 64'({cpu_go, busy}), 64'd0);
    // run, stopped by panel at an instruction boundary
    expect_ev(K_GOUP, 32'd0);
    run = 1'b1;
    tick(3);
    expect_ev(K_GODN, 32'd0);
    run = 1'b0;
    tick(3);
    check("run_stop_wait", 64'({cpu_go, busy}), 64'd1);
    expect_ev(K_IDLE, 32'd0);
    cpu_done = 1'b1;
    tick(1);
    cpu_done = 1'b0;
    tick(2);
    check("run_stop_idle", 64'(busy), 64'd0);
    // display mux and link
    cpu_ac = 12'o1111;
    cpu_ir = 12'o2222;
    cpu_pc = 12'o3333;
    cpu_link = 1'b1;
    dispsel = 2'd1;
    tick(2);
    check("disp_ac", 64'(dispout), 64'(12'o1111));
    dispsel = 2'd3;
    tick(2);
    check("disp_ir", 64'(dispout), 64'(12'o2222));
    dispsel = 2'd0;
    tick(2);
    check("disp_pc", 64'(dispout), 64'(12'o3333));
    check("linkout", 64'(linkout), 64'd1);
    tick(3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
